rvga_mem_arbiter: RTL and testbench
===================================

# rvga_mem_arbiter

Two-requester memory arbiter that shares the single cacheline-wide backing memory port between the instruction cache (fetch side) and the data cache (memory stage). It accepts one request at a time, forwards it to memory, and routes the response back to the owner. Grants are round-robin on contention so neither pipeline side starves. One transaction is outstanding at most.

## Interface
- ADDR_W, 32, byte address width (rvga_word)
- LINE_W, 128, cacheline width (rvga_cacheline)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- i_req_v  in  1  icache read request valid
- i_addr  in  ADDR_W  icache line address
- i_ready  out  1  icache request accepted this cycle
- i_resp_v  out  1  icache response valid, 1-cycle pulse
- i_rdata  out  LINE_W  icache read line
- d_req_v  in  1  dcache request valid
- d_we  in  1  dcache write (1) / read (0)
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write line
- d_ready  out  1  dcache request accepted this cycle
- d_resp_v  out  1  dcache response/write-ack, 1-cycle pulse
- d_rdata  out  LINE_W  dcache read line
- mem_req_v  out  1  memory request valid
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write line
- mem_ready  in  1  memory accepts request
- mem_resp_v  in  1  memory response/ack valid
- mem_rdata  in  LINE_W  memory read line

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (I/D), last_grant (I/D), latched we/addr/wdata, latched rdata.
- IDLE: x_ready combinational. Only i_req_v -> grant I. Only d_req_v -> grant D. Both -> grant side != last_grant. Grant: x_ready=1, latch addr/we/wdata (we=0 for I), owner<=side, last_grant<=side, -> ISSUE.
- ISSUE: mem_req_v=1 with latched fields held stable until mem_ready. mem_ready & !mem_resp_v -> WAIT. mem_ready & mem_resp_v same cycle -> capture mem_rdata, -> RESP.
- WAIT: mem_req_v=0. On mem_resp_v capture mem_rdata -> RESP.
- RESP: owner's x_resp_v=1 for exactly one cycle; x_rdata = captured line (don't-care for writes). -> IDLE.
- i_ready/d_ready are 0 outside IDLE; requesters hold req_v and fields until accepted.
- mem_resp_v in IDLE/RESP ignored; mem_ready outside ISSUE ignored.
- Non-owner resp_v never asserts; at most one of i_ready/d_ready/i_resp_v/d_resp_v per cycle for a given side.

## Timing
- Reset (rst_n=0, async): state=IDLE, last_grant=I (first tie goes to D), all outputs 0, latched data 0.
- Reset mid-transaction: transaction dropped, no x_resp_v; late mem_resp_v after reset ignored (arrives in IDLE).
- Min latency: accept cycle N, mem_req_v at N+1, mem_ready+mem_resp_v at N+1 -> x_resp_v at N+2, IDLE at N+3 (next accept at N+3). With mem_resp_v in the cycle after mem_ready: x_resp_v at N+3.
- mem_req_v rises only in the cycle after accept (registered); outputs x_rdata registered.
- Back-to-back contention alternates D, I, D, I...; single requester may be granted repeatedly.

## Test plan
- Reset then i_req_v=1 addr 0x100 alone -> i_ready at cycle 1, mem_req_v/mem_addr=0x100/mem_we=0 next cycle; mem_rdata=0xA5..A5 -> i_resp_v one pulse with i_rdata=0xA5..A5, d_resp_v stays 0.
- Both request in same cycle after reset -> D granted first (d_ready=1, i_ready=0); after D completes I granted; four consecutive contended grants order D,I,D,I.
- d_we=1 addr 0x200 wdata 0x1234.. with mem_ready stalled 5 cycles -> mem_req_v/addr/wdata held stable all 5 cycles, d_resp_v one pulse after mem_resp_v.
- mem_ready and mem_resp_v asserted same ISSUE cycle -> x_resp_v next cycle, WAIT skipped; spurious mem_resp_v in IDLE -> no resp_v.
- rst_n dropped asynchronously during WAIT -> all outputs 0 immediately; subsequent mem_resp_v produces no resp_v; new request accepted normally.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: round-robin arbiter sharing one cacheline memory port between icache and dcache.
// One transaction in flight; the response is routed back to the side that issued it.
module rvga_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_v,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_resp_v,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req_v,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_resp_v,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req_v,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_resp_v,
    input  logic [LINE_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              owner_d, last_d, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, rdata_q;
    logic              grant_i, grant_d, capture;

    // Ties go to whichever side was not granted last; grants are held off while reset is asserted.
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                grant_d  = rst_n && d_req_v && (!i_req_v || !last_d);
                grant_i  = rst_n && i_req_v && !grant_d;
                state_nx = (grant_i || grant_d) ? ISSUE : IDLE;
            end
            ISSUE: begin
                capture  = mem_ready && mem_resp_v;
                state_nx = mem_ready ? (mem_resp_v ? RESP : WAIT) : ISSUE;
            end
            WAIT: begin
                capture  = mem_resp_v;
                state_nx = mem_resp_v ? RESP : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_i || grant_d) begin
                owner_d <= grant_d;
                last_d  <= grant_d;
                we_q    <= grant_d && d_we;
                addr_q  <= grant_d ? d_addr : i_addr;
            end
            if (grant_d)
                wdata_q <= d_wdata;
            if (capture)
                rdata_q <= mem_rdata;
        end
    end

    assign i_ready   = grant_i;
    assign d_ready   = grant_d;
    assign mem_req_v = state == ISSUE;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_resp_v  = state == RESP && !owner_d;
    assign d_resp_v  = state == RESP && owner_d;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb_rvga_mem_arbiter: directed and randomized checks against a transaction-timestamp model.
// The model tracks when the in-flight transaction was accepted, taken by memory and answered.
module tb_rvga_mem_arbiter;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         i_req_v = 1'b0, d_req_v = 1'b0, d_we = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0;
    logic [127:0] d_wdata = '0, mem_rdata = '0;
    logic         mem_ready = 1'b0, mem_resp_v = 1'b0;
    logic         i_ready, i_resp_v, d_ready, d_resp_v, mem_req_v, mem_we;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0]  mem_addr;

    always #5 clk = ~clk;

    rvga_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_v(i_req_v), .i_addr(i_addr), .i_ready(i_ready), .i_resp_v(i_resp_v), .i_rdata(i_rdata),
        .d_req_v(d_req_v), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_resp_v(d_resp_v), .d_rdata(d_rdata),
        .mem_req_v(mem_req_v), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_resp_v(mem_resp_v), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: cycle k; in-flight transaction accepted at tn, taken by memory at tr, answered at ts (-1 = not yet).
    bit           active = 0, lg_d = 0, own_d = 0, m_we = 0, acc_i = 0, acc_d = 0;
    int           k = 0, tn = 0, tr = -1, ts = -1;
    logic [31:0]  m_addr = '0;
    logic [127:0] m_wdata = '0, m_rdata = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit f_req();
        return active && k > tn && tr < 0;
    endfunction

    function automatic bit f_wait();
        return active && tr >= 0 && ts < 0;
    endfunction

    function automatic bit f_resp();
        return active && ts >= 0 && k == ts + 1;
    endfunction

    task automatic tick();
        bit    gi, gd, rq, rp;
        string nm;
        #1;
        rq = f_req();
        rp = f_resp();
        gd = !active && d_req_v && (!i_req_v || !lg_d);
        gi = !active && i_req_v && !gd;
        chk("i_ready", i_ready, gi);
        chk("d_ready", d_ready, gd);
        chk("mem_req_v", mem_req_v, rq);
        chk("i_resp_v", i_resp_v, rp && !own_d);
        chk("d_resp_v", d_resp_v, rp && own_d);
        if (rq) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we)
                chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (rp && !m_we) begin
            nm = own_d ? "d_rdata" : "i_rdata";
            chk(nm, own_d ? d_rdata : i_rdata, m_rdata);
        end
        acc_i = gi;
        acc_d = gd;
        if (gi || gd) begin
            active = 1; tn = k; tr = -1; ts = -1;
            own_d = gd; lg_d = gd; m_we = gd && d_we;
            m_addr = gd ? d_addr : i_addr;
            m_wdata = d_wdata;
        end else if (rq && mem_ready) begin
            tr = k;
            if (mem_resp_v) begin
                ts = k;
                m_rdata = mem_rdata;
            end
        end else if (f_wait() && mem_resp_v) begin
            ts = k;
            m_rdata = mem_rdata;
        end
        k++;
        if (active && ts >= 0 && k >= ts + 2)
            active = 0;
        @(negedge clk);
    endtask

    task automatic auto_mem();
        mem_ready  = f_req();
        mem_resp_v = f_req();
        mem_rdata  = {4{$urandom}};
        tick();
    endtask

    task automatic drain();
        i_req_v = 0;
        d_req_v = 0;
        for (int i = 0; i < 20 && active; i++)
            auto_mem();
        if (active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: transaction still open after 20 cycles");
        end
    endtask

    task automatic rand_drive();
        if (acc_i) i_req_v = 0;
        if (acc_d) d_req_v = 0;
        if (!i_req_v && $urandom_range(0, 2) == 0) begin
            i_req_v = 1;
            i_addr  = 32'($urandom_range(0, 15)) << 4;
        end
        if (!d_req_v && $urandom_range(0, 2) == 0) begin
            d_req_v = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 15)) << 4;
            d_wdata = {4{$urandom}};
        end
        if (f_req()) begin
            mem_ready  = $urandom_range(0, 2) == 0;
            mem_resp_v = mem_ready && $urandom_range(0, 1) == 1;
        end else begin
            mem_ready  = $urandom_range(0, 3) == 0;
            mem_resp_v = $urandom_range(0, 2) == 0;
        end
        mem_rdata = {4{$urandom}};
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ord;
        int          n_ord;
        #2;
        chk("rst_mem_req_v", mem_req_v, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_resp_v", d_resp_v, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // Lone icache read, memory ready and responding in the same cycle.
        i_req_v = 1; i_addr = 32'h100;
        #1 chk("t1_i_ready", i_ready, 1);
        tick();
        i_req_v = 0; mem_ready = 1; mem_resp_v = 1; mem_rdata = {16{8'hA5}};
        #1 chk("t1_mem_req_v", mem_req_v, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        tick();
        mem_ready = 0; mem_resp_v = 0;
        #1 chk("t1_i_resp_v", i_resp_v, 1);
        chk("t1_i_rdata", i_rdata, {16{8'hA5}});
        chk("t1_d_resp_v", d_resp_v, 0);
        tick();
        #1 chk("t1_pulse_end", i_resp_v, 0);
        tick();

        // Contention: both sides keep requesting; grants must alternate starting with D.
        i_req_v = 1; i_addr = 32'h140; d_req_v = 1; d_we = 0; d_addr = 32'h300;
        #1 chk("t2_d_first", d_ready, 1);
        chk("t2_i_held", i_ready, 0);
        ord = '0;
        n_ord = 0;
        for (int i = 0; i < 16; i++) begin
            mem_ready = f_req(); mem_resp_v = f_req(); mem_rdata = {4{$urandom}};
            #1;
            if ((d_ready || i_ready) && n_ord < 4) begin
                ord = {ord[23:0], d_ready ? 8'h44 : 8'h49};
                n_ord++;
            end
            tick();
        end
        chk("t2_grant_order", ord, "DIDI");
        drain();

        // Write with memory stalling 5 cycles, then a separate response cycle.
        d_req_v = 1; d_we = 1; d_addr = 32'h200; d_wdata = 128'h12345678_9abcdef0_0fedcba9_87654321;
        #1 chk("t3_d_ready", d_ready, 1);
        tick();
        d_req_v = 0; mem_ready = 0; mem_resp_v = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_stall_req_v", mem_req_v, 1);
            chk("t3_stall_addr", mem_addr, 32'h200);
            chk("t3_stall_wdata", mem_wdata, 128'h12345678_9abcdef0_0fedcba9_87654321);
            tick();
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        mem_resp_v = 1; mem_rdata = {4{$urandom}};
        tick();
        mem_resp_v = 0;
        #1 chk("t3_d_resp_v", d_resp_v, 1);
        chk("t3_i_resp_v", i_resp_v, 0);
        tick();
        tick();

        // Spurious memory responses while idle are ignored.
        mem_ready = 1; mem_resp_v = 1;
        tick();
        tick();
        mem_ready = 0; mem_resp_v = 0;
        #1 chk("t4_no_i_resp", i_resp_v, 0);
        chk("t4_no_d_resp", d_resp_v, 0);
        tick();

        // Asynchronous reset while waiting for memory.
        i_req_v = 1; i_addr = 32'h180;
        tick();
        i_req_v = 0; mem_ready = 1;
        tick();
        mem_ready = 0;
        #2 rst_n = 0;
        #1 chk("t5_mem_req_v", mem_req_v, 0);
        chk("t5_i_resp_v", i_resp_v, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_d_rdata", d_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        active = 0; lg_d = 0;
        mem_resp_v = 1;
        tick();
        mem_resp_v = 0; d_req_v = 1; d_we = 0; d_addr = 32'h240;
        #1 chk("t5_late_resp", i_resp_v, 0);
        chk("t5_new_accept", d_ready, 1);
        tick();
        drain();

        acc_i = 0; acc_d = 0;
        for (int i = 0; i < 3000; i++)
            rand_drive();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
